// File: rtl/regfile_port_arbiter_pkg.sv
// Shared configuration for the register-file debug-port arbiter:
// FSM state encoding, requester index constants and a width helper.
package regfile_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam int unsigned REQ_VGA  = 0;
  localparam int unsigned REQ_DISP = 1;
  localparam int unsigned REQ_DBG  = 2;

  // Width of an index into n requesters, never less than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_rr_grant.sv
// Round-robin grant selector: the first asserted request at or after the
// pointer position wins. Purely combinational.
module rr_grant #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan requesters starting at the pointer, wrapping, and grant the first hit.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = PTR_W'((32'(i_ptr) + i) % N);
      if (!w_found && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        w_found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Arbitrates several requesters onto the single register-file debug port.
// One access takes two cycles after its grant (ACCESS, then RESP); a new
// grant may be issued in RESP so back-to-back accesses run every 2 cycles.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [N_REQ-1:0]        iReq,
  input  logic [N_REQ*ADDR_W-1:0] iAddr,
  input  logic                    iWrite,
  input  logic [DATA_W-1:0]       iWData,
  input  logic                    iCoreHalt,
  output logic [N_REQ-1:0]        oGnt,
  output logic [N_REQ-1:0]        oValid,
  output logic [DATA_W-1:0]       oRData,
  output logic [ADDR_W-1:0]       oRfAddr,
  output logic                    oRfWrite,
  output logic [DATA_W-1:0]       oRfWData,
  input  logic [DATA_W-1:0]       iRfData
);

  localparam int unsigned      PTR_W = ptr_width(N_REQ);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(N_REQ - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_armed;
  logic [PTR_W-1:0]    r_ptr;
  logic [N_REQ-1:0]    r_sel;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;

  logic [N_REQ-1:0]    w_elig;
  logic [N_REQ-1:0]    w_rr_gnt;
  logic [N_REQ-1:0]    w_gnt;
  logic                w_any;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [ADDR_W-1:0]   w_gnt_addr;
  logic                w_rf_we;

  // A debug-host write waits ungranted until the core is halted.
  always_comb begin
    w_elig = iReq;
    if (iWrite && !iCoreHalt) w_elig[N_REQ-1] = 1'b0;
  end

  rr_grant #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_grant (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt)
  );

  // Grants only outside ACCESS, and only once a posedge has passed since
  // reset release (r_armed), so no grant can slip in before the first edge.
  always_comb begin
    w_gnt = '0;
    if (r_armed && (r_state != ST_ACCESS)) w_gnt = w_rr_gnt;
    w_any = |w_gnt;
  end

  // Encode the one-hot grant and pick the granted requester's index slice.
  always_comb begin
    w_gnt_idx  = '0;
    w_gnt_addr = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt[k]) begin
        w_gnt_idx  = PTR_W'(k);
        w_gnt_addr = iAddr[k*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE, ST_RESP: w_next = w_any ? ST_ACCESS : ST_IDLE;
      ST_ACCESS:        w_next = ST_RESP;
      default:          w_next = ST_IDLE;
    endcase
  end

  // State register and post-reset arming flag.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= ST_IDLE;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_next;
      r_armed <= 1'b1;
    end
  end

  // Round-robin pointer moves to the requester after the one just granted.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Latch the granted transaction; capture the response during ACCESS.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sel   <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_any) begin
        r_sel   <= w_gnt;
        r_addr  <= w_gnt_addr;
        r_wr    <= iWrite & w_gnt[N_REQ-1];
        r_wdata <= iWData;
      end
      if (r_state == ST_ACCESS) begin
        if (r_wr) r_rdata <= (r_addr == '0) ? '0 : r_wdata;
        else      r_rdata <= iRfData;
      end
    end
  end

  assign w_rf_we = r_wr && (r_addr != '0);

  // Port muxing: the shared port is driven only in ACCESS, responses only in RESP.
  always_comb begin
    oGnt     = w_gnt;
    oValid   = '0;
    oRData   = '0;
    oRfAddr  = '0;
    oRfWrite = 1'b0;
    oRfWData = '0;
    case (r_state)
      ST_ACCESS: begin
        oRfAddr  = r_addr;
        oRfWrite = w_rf_we;
        oRfWData = w_rf_we ? r_wdata : '0;
      end
      ST_RESP: begin
        oValid = r_sel;
        oRData = r_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: a transaction-level model
// (grant -> access slot -> response slot) checked every negedge, plus
// hand-computed literal expectations for the directed scenarios.
module tb_regfile_port_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            iCLK = 1'b0;
  logic            iRST_N;
  logic [N-1:0]    iReq;
  logic [N*AW-1:0] iAddr;
  logic            iWrite;
  logic [DW-1:0]   iWData;
  logic            iCoreHalt;
  logic [N-1:0]    oGnt;
  logic [N-1:0]    oValid;
  logic [DW-1:0]   oRData;
  logic [AW-1:0]   oRfAddr;
  logic            oRfWrite;
  logic [DW-1:0]   oRfWData;
  logic [DW-1:0]   iRfData;

  int checks   = 0;
  int failures = 0;
  logic tb_init;

  regfile_port_arbiter #(
    .N_REQ  (N),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iReq      (iReq),
    .iAddr     (iAddr),
    .iWrite    (iWrite),
    .iWData    (iWData),
    .iCoreHalt (iCoreHalt),
    .oGnt      (oGnt),
    .oValid    (oValid),
    .oRData    (oRData),
    .oRfAddr   (oRfAddr),
    .oRfWrite  (oRfWrite),
    .oRfWData  (oRfWData),
    .iRfData   (iRfData)
  );

  always #5 iCLK = ~iCLK;

  function automatic logic [DW-1:0] rf_init(input int i);
    return (i == 5) ? 32'h0000_1234 : (32'h1000_0000 + 32'(i));
  endfunction

  // Register file seen by the DUT's debug port.
  logic [DW-1:0] rf [32];
  always @(posedge iCLK) begin
    if (!tb_init) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
    end else if (oRfWrite) begin
      rf[oRfAddr] <= oRfWData;
    end
  end
  assign iRfData = rf[oRfAddr];

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mrf [32];
  logic          m_armed;
  int            m_ptr;
  logic          m_acc_v;
  int            m_acc_k;
  logic [AW-1:0] m_acc_addr;
  logic          m_acc_wr;
  logic [DW-1:0] m_acc_wd;
  logic          m_rsp_v;
  int            m_rsp_k;
  logic [DW-1:0] m_rsp_d;

  // Requester the rules say must be granted this cycle, or -1.
  function automatic int model_pick();
    if (!iRST_N || !m_armed || m_acc_v) return -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (iReq[k] && !(k == N - 1 && iWrite && !iCoreHalt)) return k;
    end
    return -1;
  endfunction

  function automatic logic [AW-1:0] pick_addr(input int k);
    return (k >= 0) ? iAddr[k*AW +: AW] : '0;
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    logic [N-1:0] g;
    int p;
    g = '0;
    p = model_pick();
    if (p >= 0) g[p] = 1'b1;
    return g;
  endfunction

  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    v = '0;
    if (m_rsp_v) v[m_rsp_k] = 1'b1;
    return v;
  endfunction

  always @(posedge iCLK or negedge iRST_N) begin
    if (!tb_init || !iRST_N) begin
      if (!tb_init) for (int i = 0; i < 32; i++) mrf[i] <= rf_init(i);
      m_armed <= 1'b0;
      m_ptr   <= 0;
      m_acc_v <= 1'b0;
      m_acc_k <= 0;
      m_acc_addr <= '0;
      m_acc_wr <= 1'b0;
      m_acc_wd <= '0;
      m_rsp_v <= 1'b0;
      m_rsp_k <= 0;
      m_rsp_d <= '0;
    end else begin
      m_armed <= 1'b1;
      m_rsp_v <= m_acc_v;
      m_rsp_k <= m_acc_k;
      m_rsp_d <= m_acc_wr ? ((m_acc_addr == 0) ? '0 : m_acc_wd) : mrf[m_acc_addr];
      if (m_acc_v && m_acc_wr && m_acc_addr != 0) mrf[m_acc_addr] <= m_acc_wd;
      m_acc_v    <= (model_pick() >= 0);
      m_acc_k    <= (model_pick() >= 0) ? model_pick() : 0;
      m_acc_addr <= pick_addr(model_pick());
      m_acc_wr   <= (model_pick() == N - 1) && iWrite;
      m_acc_wd   <= iWData;
      if (model_pick() >= 0) m_ptr <= (model_pick() + 1) % N;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge iCLK) begin
    if (tb_init) begin
      if (!iRST_N) begin
        chk("rst_gnt", 64'(oGnt), 64'd0);
        chk("rst_valid", 64'(oValid), 64'd0);
        chk("rst_rfwrite", 64'(oRfWrite), 64'd0);
        chk("rst_rfaddr", 64'(oRfAddr), 64'd0);
      end else begin
        chk("cmp_gnt", 64'(oGnt), 64'(exp_gnt()));
        chk("cmp_valid", 64'(oValid), 64'(exp_valid()));
        if (m_rsp_v) chk("cmp_rdata", 64'(oRData), 64'(m_rsp_d));
        chk("cmp_rfaddr", 64'(oRfAddr), m_acc_v ? 64'(m_acc_addr) : 64'd0);
        chk("cmp_rfwrite", 64'(oRfWrite), 64'(m_acc_v && m_acc_wr && m_acc_addr != 0));
        chk("cmp_rfwdata", 64'(oRfWData),
            (m_acc_v && m_acc_wr && m_acc_addr != 0) ? 64'(m_acc_wd) : 64'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_addr(input int k, input logic [AW-1:0] a);
    iAddr[k*AW +: AW] = a;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 64'(oGnt), 64'd0);
    chk({tag, "_valid"}, 64'(oValid), 64'd0);
    chk({tag, "_rdata"}, 64'(oRData), 64'd0);
    chk({tag, "_rfaddr"}, 64'(oRfAddr), 64'd0);
    chk({tag, "_rfwrite"}, 64'(oRfWrite), 64'd0);
    chk({tag, "_rfwdata"}, 64'(oRfWData), 64'd0);
  endtask

  logic [N-1:0] cont_g [7];
  logic [N-1:0] cont_v [7];

  initial begin
    tb_init   = 1'b0;
    iRST_N    = 1'b0;
    iReq      = '0;
    iAddr     = '0;
    iWrite    = 1'b0;
    iWData    = '0;
    iCoreHalt = 1'b0;
    step();
    tb_init = 1'b1;
    iReq = 3'b111;
    #1 chk_all_zero("reset");
    iReq = '0;
    step();
    iRST_N = 1'b1;
    step();

    // Single read
    iReq = 3'b001;
    set_addr(0, 5'd5);
    #1 chk("s1_gnt", 64'(oGnt), 64'h1);
    step();
    iReq = '0;
    #1 chk("s1_rfaddr", 64'(oRfAddr), 64'd5);
    chk("s1_rfwrite", 64'(oRfWrite), 64'd0);
    step();
    #1 chk("s1_valid", 64'(oValid), 64'h1);
    chk("s1_rdata", 64'(oRData), 64'h1234);
    step();

    // Reset pulse so contention starts from pointer 0
    iRST_N = 1'b0;
    step();
    iRST_N = 1'b1;
    step();

    // Contention: all three held
    cont_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    cont_v = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100};
    set_addr(0, 5'd1);
    set_addr(1, 5'd2);
    set_addr(2, 5'd3);
    iWrite = 1'b0;
    iReq = 3'b111;
    for (int c = 0; c < 7; c++) begin
      #1 chk($sformatf("cont_gnt%0d", c), 64'(oGnt), 64'(cont_g[c]));
      chk($sformatf("cont_valid%0d", c), 64'(oValid), 64'(cont_v[c]));
      if (c == 4) chk("cont_rdata_disp", 64'(oRData), 64'h1000_0002);
      step();
    end
    iReq = '0;
    step();
    step();

    // Gated write: waits while the core runs
    iReq = 3'b100;
    iWrite = 1'b1;
    iCoreHalt = 1'b0;
    set_addr(2, 5'd7);
    iWData = 32'hCAFE_0007;
    for (int c = 0; c < 10; c++) begin
      #1 chk($sformatf("gw_wait%0d", c), 64'(oGnt), 64'd0);
      step();
    end
    iCoreHalt = 1'b1;
    #1 chk("gw_gnt", 64'(oGnt), 64'h4);
    step();
    iCoreHalt = 1'b0;
    iReq = '0;
    iWrite = 1'b0;
    #1 chk("gw_rfwrite", 64'(oRfWrite), 64'd1);
    chk("gw_rfaddr", 64'(oRfAddr), 64'd7);
    chk("gw_rfwdata", 64'(oRfWData), 64'hCAFE_0007);
    step();
    #1 chk("gw_valid", 64'(oValid), 64'h4);
    chk("gw_rdata", 64'(oRData), 64'hCAFE_0007);
    chk("gw_rfwrite_off", 64'(oRfWrite), 64'd0);
    step();

    // Write to index 0
    iCoreHalt = 1'b1;
    iReq = 3'b100;
    iWrite = 1'b1;
    set_addr(2, 5'd0);
    iWData = 32'hDEAD_BEEF;
    #1 chk("x0_gnt", 64'(oGnt), 64'h4);
    step();
    iReq = '0;
    iWrite = 1'b0;
    #1 chk("x0_rfwrite", 64'(oRfWrite), 64'd0);
    step();
    #1 chk("x0_valid", 64'(oValid), 64'h4);
    chk("x0_rdata", 64'(oRData), 64'd0);
    step();

    // Read back the earlier write from the register-display port
    iReq = 3'b010;
    set_addr(1, 5'd7);
    #1 chk("rb_gnt", 64'(oGnt), 64'h2);
    step();
    iReq = '0;
    step();
    #1 chk("rb_valid", 64'(oValid), 64'h2);
    chk("rb_rdata", 64'(oRData), 64'hCAFE_0007);
    step();

    // Mid-access reset
    iReq = 3'b001;
    set_addr(0, 5'd5);
    #1 chk("ma_gnt", 64'(oGnt), 64'h1);
    step();
    iReq = '0;
    #1 chk("ma_rfaddr", 64'(oRfAddr), 64'd5);
    iRST_N = 1'b0;
    #1 chk_all_zero("ma_rst");
    step();
    #1 chk("ma_novalid", 64'(oValid), 64'd0);
    step();
    iRST_N = 1'b1;
    iReq = 3'b011;
    set_addr(0, 5'd3);
    set_addr(1, 5'd4);
    #1 chk("ma_early", 64'(oGnt), 64'd0);
    step();
    #1 chk("ma_first", 64'(oGnt), 64'h1);
    step();
    iReq = 3'b010;
    step();
    #1 chk("ma_second", 64'(oGnt), 64'h2);
    chk("ma_valid0", 64'(oValid), 64'h1);
    chk("ma_rdata0", 64'(oRData), 64'h1000_0003);
    step();
    iReq = '0;
    step();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
